// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: opcode/funct values, ALU selectors, EX/MEM record.
// The EX_MULT_EN build additionally uses FN_MULT/FN_MFHI/FN_MFLO.
package ex_pkg;

   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2a;
   localparam logic [5:0] FN_SLTU  = 6'h2b;

   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ITYPE = 2'b11
   } alu_op_e;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_ZERO
   } alu_ctl_t;

   typedef struct packed {
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
      logic [31:0] alu_result;
      logic [31:0] wdata;
      logic [4:0]  wr_reg;
   } exmem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, front-end redirect/stall and EX/MEM outputs of the execute stage.
// master = ID/EX side driving the stage, slave = ex_stage.
interface ex_stage_if;
   logic        branch_ex, jump_ex, jump_reg_ex, reg_dst_ex, alu_src_ex;
   logic [1:0]  alu_op_ex;
   logic        mem_read_ex, mem_write_ex, mem_to_reg_ex, reg_write_ex;
   logic [31:0] pc4_ex, rdata1_ex, rdata2_ex, imm_ext_ex;
   logic [25:0] instr_index_ex;
   logic [4:0]  rt_ex, rd_ex;
   logic [5:0]  funct_ex, opcode_ex;

   logic        redirect, ifid_flush, idex_flush, ex_stall;
   logic [31:0] redirect_pc;
   logic        mem_read_mem, mem_write_mem, mem_to_reg_mem, reg_write_mem;
   logic [31:0] alu_result_mem, wdata_mem;
   logic [4:0]  wr_reg_mem;

   modport slave (
      input  branch_ex, jump_ex, jump_reg_ex, reg_dst_ex, alu_src_ex, alu_op_ex,
             mem_read_ex, mem_write_ex, mem_to_reg_ex, reg_write_ex,
             pc4_ex, rdata1_ex, rdata2_ex, imm_ext_ex, instr_index_ex,
             rt_ex, rd_ex, funct_ex, opcode_ex,
      output redirect, redirect_pc, ifid_flush, idex_flush, ex_stall,
             mem_read_mem, mem_write_mem, mem_to_reg_mem, reg_write_mem,
             alu_result_mem, wdata_mem, wr_reg_mem
   );

   modport master (
      output branch_ex, jump_ex, jump_reg_ex, reg_dst_ex, alu_src_ex, alu_op_ex,
             mem_read_ex, mem_write_ex, mem_to_reg_ex, reg_write_ex,
             pc4_ex, rdata1_ex, rdata2_ex, imm_ext_ex, instr_index_ex,
             rt_ex, rd_ex, funct_ex, opcode_ex,
      input  redirect, redirect_pc, ifid_flush, idex_flush, ex_stall,
             mem_read_mem, mem_write_mem, mem_to_reg_mem, reg_write_mem,
             alu_result_mem, wdata_mem, wr_reg_mem
   );
endinterface

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU; shifts operate on b by shamt, everything wraps mod 2^32.
module ex_alu
   import ex_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  alu_ctl_t    ctl,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (ctl)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NOR:  result = ~(a | b);
         ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: result = {31'b0, a < b};
         ALU_SLL:  result = b << shamt;
         ALU_SRL:  result = b >> shamt;
         ALU_SRA:  result = $signed(b) >>> shamt;
         ALU_LUI:  result = {b[15:0], 16'h0};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS EX stage: ALU, branch/jump resolution with front-end redirect, EX/MEM register.
// Define EX_MULT_EN for the iterative signed mult (HI/LO, mfhi/mflo) that stalls the front end.
module ex_stage
   import ex_pkg::*;
`ifdef EX_MULT_EN
#(
   parameter int MULT_CYCLES = 32  // one multiplier bit per step, so 32 for full 32x32
)
`endif
(
   input  logic       clk,
   input  logic       rst_n,
   ex_stage_if.slave  bus
);

   logic [31:0] alu_a, alu_b, alu_res, result;
   alu_ctl_t    alu_ctl;
   logic        is_jal, taken, busy, mult_start;
   exmem_t      exmem_q, exmem_d;

   always_comb begin
      alu_a   = bus.rdata1_ex;
      alu_b   = bus.alu_src_ex ? bus.imm_ext_ex : bus.rdata2_ex;
      alu_ctl = ALU_ZERO;
      case (bus.alu_op_ex)
         ALUOP_ADD: alu_ctl = ALU_ADD;
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_RTYPE: begin
            case (bus.funct_ex)
               FN_ADD, FN_ADDU: alu_ctl = ALU_ADD;
               FN_SUB, FN_SUBU: alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_XOR:  alu_ctl = ALU_XOR;
               FN_NOR:  alu_ctl = ALU_NOR;
               FN_SLT:  alu_ctl = ALU_SLT;
               FN_SLTU: alu_ctl = ALU_SLTU;
               FN_SLL:  alu_ctl = ALU_SLL;
               FN_SRL:  alu_ctl = ALU_SRL;
               FN_SRA:  alu_ctl = ALU_SRA;
               default: alu_ctl = ALU_ZERO;
            endcase
         end
         default: begin
            // logical immediates see a zero-extended operand
            case (bus.opcode_ex)
               OP_ADDI, OP_ADDIU: alu_ctl = ALU_ADD;
               OP_SLTI:  alu_ctl = ALU_SLT;
               OP_SLTIU: alu_ctl = ALU_SLTU;
               OP_ANDI: begin alu_ctl = ALU_AND; alu_b = {16'h0, bus.imm_ext_ex[15:0]}; end
               OP_ORI:  begin alu_ctl = ALU_OR;  alu_b = {16'h0, bus.imm_ext_ex[15:0]}; end
               OP_XORI: begin alu_ctl = ALU_XOR; alu_b = {16'h0, bus.imm_ext_ex[15:0]}; end
               OP_LUI:   alu_ctl = ALU_LUI;
               default:  alu_ctl = ALU_ZERO;
            endcase
         end
      endcase
   end

   ex_alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .shamt  (bus.imm_ext_ex[10:6]),
      .ctl    (alu_ctl),
      .result (alu_res)
   );

`ifdef EX_MULT_EN
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam int         CNT_W   = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      mcand_q, mcand_d, acc_q, acc_d, acc_step;
   logic [31:0]      mplr_q, mplr_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b;
   logic             neg_q, neg_d;

   assign busy       = (state_q == ST_BUSY);
   assign mult_start = !busy && (bus.alu_op_ex == ALUOP_RTYPE) && (bus.funct_ex == FN_MULT);
   assign abs_a      = bus.rdata1_ex[31] ? -bus.rdata1_ex : bus.rdata1_ex;
   assign abs_b      = bus.rdata2_ex[31] ? -bus.rdata2_ex : bus.rdata2_ex;

   // Unsigned shift-add on magnitudes; the sign is applied once on the last step.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      acc_step = acc_q + (mplr_q[0] ? mcand_q : 64'd0);
      case (state_q)
         ST_BUSY: begin
            acc_d   = acc_step;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MULT_CYCLES - 1)) begin
               state_d      = ST_DONE;
               {hi_d, lo_d} = neg_q ? -acc_step : acc_step;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (mult_start) begin
         state_d = ST_BUSY;
         cnt_d   = '0;
         acc_d   = '0;
         mcand_d = {32'h0, abs_a};
         mplr_d  = abs_b;
         neg_d   = bus.rdata1_ex[31] ^ bus.rdata2_ex[31];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
`else
   assign busy       = 1'b0;
   assign mult_start = 1'b0;
`endif

   always_comb begin
      is_jal = bus.jump_ex && (bus.opcode_ex == OP_JAL);
      taken  = bus.branch_ex &&
               (((bus.opcode_ex == OP_BEQ) && (bus.rdata1_ex == bus.rdata2_ex)) ||
                ((bus.opcode_ex == OP_BNE) && (bus.rdata1_ex != bus.rdata2_ex)));
      result = alu_res;
`ifdef EX_MULT_EN
      if (bus.alu_op_ex == ALUOP_RTYPE && bus.funct_ex == FN_MFHI) result = hi_q;
      if (bus.alu_op_ex == ALUOP_RTYPE && bus.funct_ex == FN_MFLO) result = lo_q;
`endif
      if (is_jal) result = bus.pc4_ex;

      // The instruction held in EX during a mult is resolved only once the stall drops.
      exmem_d = '0;
      if (!busy && !mult_start) begin
         exmem_d.mem_read   = bus.mem_read_ex;
         exmem_d.mem_write  = bus.mem_write_ex;
         exmem_d.mem_to_reg = bus.mem_to_reg_ex;
         exmem_d.reg_write  = bus.reg_write_ex | is_jal;
         exmem_d.alu_result = result;
         exmem_d.wdata      = bus.rdata2_ex;
         exmem_d.wr_reg     = is_jal ? REG_RA : (bus.reg_dst_ex ? bus.rd_ex : bus.rt_ex);
      end
   end

   assign bus.redirect    = (taken || bus.jump_ex || bus.jump_reg_ex) && !busy;
   assign bus.redirect_pc = bus.jump_reg_ex ? bus.rdata1_ex :
                            bus.jump_ex     ? {bus.pc4_ex[31:28], bus.instr_index_ex, 2'b00} :
                                              bus.pc4_ex + {bus.imm_ext_ex[29:0], 2'b00};
   assign bus.ifid_flush  = bus.redirect;
   assign bus.idex_flush  = bus.redirect;
   assign bus.ex_stall    = busy;

   always_ff @(posedge clk) begin
      if (!rst_n) exmem_q <= '0;
      else        exmem_q <= exmem_d;
   end

   assign bus.mem_read_mem   = exmem_q.mem_read;
   assign bus.mem_write_mem  = exmem_q.mem_write;
   assign bus.mem_to_reg_mem = exmem_q.mem_to_reg;
   assign bus.reg_write_mem  = exmem_q.reg_write;
   assign bus.alu_result_mem = exmem_q.alu_result;
   assign bus.wdata_mem      = exmem_q.wdata;
   assign bus.wr_reg_mem     = exmem_q.wr_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Random + directed bench for ex_stage against an instruction-level reference model.
// Build with EX_MULT_EN to also cover the mult/mfhi/mflo path.
module tb_ex_stage;

`ifdef EX_MULT_EN
   localparam bit HAS_MULT = 1'b1;
`else
   localparam bit HAS_MULT = 1'b0;
`endif
   localparam int MULT_CYCLES = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_stage_if bus ();
   ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      bit mr, mw, m2r, rw;
      bit [31:0] res, wd;
      bit [4:0]  wr;
   } mem_t;

   mem_t      exp_mem;
   bit [31:0] m_hi, m_lo;
   bit [63:0] m_pend;
   int        m_busy;
   bit        e_stall, e_redir;
   int        n_tests = 0, n_fail = 0;

   logic [5:0] fn_tab [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h18, 6'h10, 6'h12, 6'h3f};
   logic [5:0] op_tab [8]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Architectural result of the instruction currently presented to EX.
   function automatic bit [31:0] ref_result();
      bit [31:0] a = bus.rdata1_ex;
      bit [31:0] imm = bus.imm_ext_ex;
      bit [31:0] b = bus.alu_src_ex ? imm : bus.rdata2_ex;
      bit [31:0] zimm = {16'h0, imm[15:0]};
      bit [4:0]  sh = imm[10:6];
      bit [31:0] r = 0;
      if (bus.jump_ex && bus.opcode_ex == 6'h03) return bus.pc4_ex;
      case (bus.alu_op_ex)
         2'b00: r = a + b;
         2'b01: r = a - b;
         2'b10: case (bus.funct_ex)
            6'h20, 6'h21: r = a + b;
            6'h22, 6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2a: r = ($signed(a) < $signed(b)) ? 1 : 0;
            6'h2b: r = (a < b) ? 1 : 0;
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = $signed(b) >>> sh;
            6'h10: r = HAS_MULT ? m_hi : 0;
            6'h12: r = HAS_MULT ? m_lo : 0;
            default: r = 0;
         endcase
         default: case (bus.opcode_ex)
            6'h08, 6'h09: r = a + b;
            6'h0a: r = ($signed(a) < $signed(b)) ? 1 : 0;
            6'h0b: r = (a < b) ? 1 : 0;
            6'h0c: r = a & zimm;
            6'h0d: r = a | zimm;
            6'h0e: r = a ^ zimm;
            6'h0f: r = {imm[15:0], 16'h0};
            default: r = 0;
         endcase
      endcase
      return r;
   endfunction

   task automatic check_comb();
      bit [31:0] a = bus.rdata1_ex, pc4 = bus.pc4_ex, tgt;
      bit taken = bus.branch_ex && ((bus.opcode_ex == 6'h04 && a == bus.rdata2_ex) ||
                                    (bus.opcode_ex == 6'h05 && a != bus.rdata2_ex));
      e_stall = HAS_MULT && (m_busy > 0);
      e_redir = !e_stall && (taken || bus.jump_ex || bus.jump_reg_ex);
      chk("ex_stall", bus.ex_stall, e_stall);
      chk("redirect", bus.redirect, e_redir);
      chk("ifid_flush", bus.ifid_flush, e_redir);
      chk("idex_flush", bus.idex_flush, e_redir);
      if (e_redir) begin
         if (bus.jump_reg_ex)  tgt = a;
         else if (bus.jump_ex) tgt = {pc4[31:28], bus.instr_index_ex, 2'b00};
         else                  tgt = pc4 + bus.imm_ext_ex * 4;
         chk("redirect_pc", bus.redirect_pc, tgt);
      end
   endtask

   task automatic model_clock();
      bit is_jal = bus.jump_ex && bus.opcode_ex == 6'h03;
      bit is_mult = bus.alu_op_ex == 2'b10 && bus.funct_ex == 6'h18;
      longint sa = longint'($signed(bus.rdata1_ex));
      longint sb = longint'($signed(bus.rdata2_ex));
      if (!rst_n) begin
         exp_mem = '0; m_hi = 0; m_lo = 0; m_busy = 0;
      end else if (HAS_MULT && m_busy > 0) begin
         exp_mem = '0;
         m_busy--;
         if (m_busy == 0) {m_hi, m_lo} = m_pend;
      end else if (HAS_MULT && is_mult) begin
         exp_mem = '0;
         m_busy  = MULT_CYCLES;
         m_pend  = sa * sb;
      end else begin
         exp_mem.mr  = bus.mem_read_ex;
         exp_mem.mw  = bus.mem_write_ex;
         exp_mem.m2r = bus.mem_to_reg_ex;
         exp_mem.rw  = bus.reg_write_ex | is_jal;
         exp_mem.res = ref_result();
         exp_mem.wd  = bus.rdata2_ex;
         exp_mem.wr  = is_jal ? 5'd31 : (bus.reg_dst_ex ? bus.rd_ex : bus.rt_ex);
      end
   endtask

   task automatic check_regs();
      chk("mem_read_mem", bus.mem_read_mem, exp_mem.mr);
      chk("mem_write_mem", bus.mem_write_mem, exp_mem.mw);
      chk("mem_to_reg_mem", bus.mem_to_reg_mem, exp_mem.m2r);
      chk("reg_write_mem", bus.reg_write_mem, exp_mem.rw);
      chk("alu_result_mem", bus.alu_result_mem, exp_mem.res);
      chk("wdata_mem", bus.wdata_mem, exp_mem.wd);
      chk("wr_reg_mem", bus.wr_reg_mem, exp_mem.wr);
   endtask

   // One EX cycle: inputs are already driven (posedge+1); checks comb, clocks, checks EX/MEM.
   task automatic cyc();
      #1;
      check_comb();
      model_clock();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic set_bubble();
      {bus.branch_ex, bus.jump_ex, bus.jump_reg_ex, bus.reg_dst_ex, bus.alu_src_ex} = '0;
      {bus.mem_read_ex, bus.mem_write_ex, bus.mem_to_reg_ex, bus.reg_write_ex} = '0;
      bus.alu_op_ex = 2'b00;
      bus.pc4_ex = $urandom; bus.rdata1_ex = $urandom; bus.rdata2_ex = $urandom;
      bus.imm_ext_ex = $urandom; bus.instr_index_ex = 26'($urandom);
      bus.rt_ex = 5'($urandom); bus.rd_ex = 5'($urandom);
      bus.funct_ex = 6'($urandom); bus.opcode_ex = 6'h00;
   endtask

   task automatic set_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [4:0] sh);
      set_bubble();
      bus.alu_op_ex = 2'b10; bus.reg_dst_ex = 1'b1; bus.reg_write_ex = 1'b1;
      bus.rdata1_ex = a; bus.rdata2_ex = b; bus.rd_ex = rd; bus.funct_ex = fn;
      bus.imm_ext_ex = {{16{rd[4]}}, rd, sh, fn};
   endtask

   task automatic set_i(input logic [5:0] op, input logic [31:0] a, input logic [15:0] imm);
      set_bubble();
      bus.alu_op_ex = 2'b11; bus.alu_src_ex = 1'b1; bus.reg_write_ex = 1'b1;
      bus.opcode_ex = op; bus.rdata1_ex = a; bus.imm_ext_ex = {{16{imm[15]}}, imm};
   endtask

   task automatic set_br(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc4, input logic [15:0] imm);
      set_bubble();
      bus.branch_ex = 1'b1; bus.alu_op_ex = 2'b01; bus.opcode_ex = op;
      bus.rdata1_ex = a; bus.rdata2_ex = b; bus.pc4_ex = pc4;
      bus.imm_ext_ex = {{16{imm[15]}}, imm};
   endtask

   task automatic set_j(input logic [5:0] op, input logic [31:0] pc4, input logic [25:0] idx);
      set_bubble();
      bus.jump_ex = 1'b1; bus.opcode_ex = op; bus.pc4_ex = pc4; bus.instr_index_ex = idx;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 15));
         1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
         2: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic gen_random();
      logic [31:0] x = rnd_val();
      logic [31:0] y = ($urandom_range(0, 1) == 1) ? x : rnd_val();
      case ($urandom_range(0, 9))
         0: set_bubble();
         1, 2, 3: set_r(fn_tab[$urandom_range(0, 16)], x, y, 5'($urandom), 5'($urandom));
         4, 5: set_i(op_tab[$urandom_range(0, 7)], x, 16'($urandom));
         6: begin
            set_i(($urandom_range(0, 1) == 1) ? 6'h23 : 6'h2b, x, 16'($urandom));
            bus.alu_op_ex = 2'b00; bus.rdata2_ex = y;
            bus.mem_read_ex = (bus.opcode_ex == 6'h23);
            bus.mem_to_reg_ex = bus.mem_read_ex;
            bus.reg_write_ex = bus.mem_read_ex;
            bus.mem_write_ex = !bus.mem_read_ex;
         end
         7: set_br(($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05, x, y, $urandom, 16'($urandom));
         8: set_j(($urandom_range(0, 1) == 1) ? 6'h02 : 6'h03, $urandom, 26'($urandom));
         default: begin
            set_r(6'h08, x, y, 5'd0, 5'd0);
            bus.jump_reg_ex = 1'b1; bus.reg_write_ex = 1'b0;
         end
      endcase
   endtask

   initial begin
      int n_st;
      set_bubble();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_mem = '0; m_hi = 0; m_lo = 0; m_busy = 0;
      cyc();
      chk("reset_alu_result", bus.alu_result_mem, 32'h0);
      chk("reset_reg_write", bus.reg_write_mem, 1'b0);
      rst_n = 1'b1;

      set_r(6'h20, 32'd5, 32'd7, 5'd3, 5'd0); cyc();
      chk("add_result", bus.alu_result_mem, 32'd12);
      chk("add_wr_reg", bus.wr_reg_mem, 5'd3);
      chk("model_add", exp_mem.res, 32'd12);

      set_br(6'h04, 32'd9, 32'd9, 32'h100, 16'd4); #1;
      chk("beq_redirect", bus.redirect, 1'b1);
      chk("beq_target", bus.redirect_pc, 32'h110);
      chk("beq_ifid_flush", bus.ifid_flush, 1'b1);
      chk("beq_idex_flush", bus.idex_flush, 1'b1);
      cyc();
      set_br(6'h04, 32'd9, 32'd8, 32'h100, 16'd4); #1;
      chk("beq_ne_redirect", bus.redirect, 1'b0);
      cyc();

      set_j(6'h03, 32'h0040_0008, 26'h40); #1;
      chk("jal_target", bus.redirect_pc, 32'h0000_0100);
      cyc();
      chk("jal_wr_reg", bus.wr_reg_mem, 5'd31);
      chk("jal_link", bus.alu_result_mem, 32'h0040_0008);
      chk("jal_reg_write", bus.reg_write_mem, 1'b1);

      set_r(6'h2a, 32'hFFFF_FFFF, 32'd1, 5'd4, 5'd0); cyc();
      chk("slt_neg", bus.alu_result_mem, 32'd1);
      set_r(6'h2b, 32'h1234_5678, 32'h1234_5678, 5'd4, 5'd0); cyc();
      chk("sltu_equal", bus.alu_result_mem, 32'd0);
      set_i(6'h0f, 32'hDEAD_BEEF, 16'h1234); cyc();
      chk("lui", bus.alu_result_mem, 32'h1234_0000);
      set_i(6'h0d, 32'h0, 16'hFFFF); cyc();
      chk("ori_zext", bus.alu_result_mem, 32'h0000_FFFF);
      chk("model_ori", exp_mem.res, 32'h0000_FFFF);
      set_r(6'h03, 32'h0, 32'h8000_0000, 5'd4, 5'd4); cyc();
      chk("sra", bus.alu_result_mem, 32'hF800_0000);

      set_r(6'h20, 32'd5, 32'd7, 5'd3, 5'd0); rst_n = 1'b0; cyc(); rst_n = 1'b1;
      chk("rst_stream_result", bus.alu_result_mem, 32'h0);
      chk("rst_stream_wr_reg", bus.wr_reg_mem, 5'd0);
      chk("rst_stream_stall", bus.ex_stall, 1'b0);

`ifdef EX_MULT_EN
      set_r(6'h18, 32'hFFFF_FFFF, 32'd2, 5'd0, 5'd0); cyc();
      set_r(6'h10, 32'h0, 32'h0, 5'd6, 5'd0);
      n_st = 0;
      for (int i = 0; i < 40 && bus.ex_stall === 1'b1; i++) begin n_st++; cyc(); end
      chk("mult_stall_cycles", n_st, 32);
      cyc();
      chk("mfhi", bus.alu_result_mem, 32'hFFFF_FFFF);
      set_r(6'h12, 32'h0, 32'h0, 5'd7, 5'd0); cyc();
      chk("mflo", bus.alu_result_mem, 32'hFFFF_FFFE);
      set_r(6'h18, 32'd7, 32'd9, 5'd0, 5'd0); cyc();
      set_r(6'h10, 32'h0, 32'h0, 5'd6, 5'd0); cyc(); cyc();
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      chk("rst_mult_stall", bus.ex_stall, 1'b0);
      chk("rst_mult_result", bus.alu_result_mem, 32'h0);
      cyc();
      chk("rst_mult_hi", bus.alu_result_mem, 32'h0);
`endif

      for (int i = 0; i < 3000; i++) begin
         if (e_stall)      ;
         else if (e_redir) set_bubble();
         else              gen_random();
         rst_n = ($urandom_range(0, 199) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
